bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter: the next-generation counting core behind the seven-segment display path. It adds per-instance digit count, programmable modulo (MAX_VALUE), wrap or saturate mode, a built-in tick prescaler and a sequential binary-to-BCD loader (shift-add-3). It sits between the debounced button/switch conditioning and the per-digit seven-segment decoders, which consume `bcd_out` nibble by nibble.

---
 rtl/bcd_updown_counter.sv | 247 ++++++++++++++++++++++++
 tb/tb_bcd_updown_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//   Multi-digit BCD up/down counter with a programmable modulo, wrap or
//   saturate behaviour at the limits, a built-in tick prescaler, and a
//   sequential binary-to-BCD loader that uses the shift-add-3 method.
//
// Ports
//   clk       : rising-edge clock
//   rst_btn   : synchronous active-low reset
//   clear     : synchronous clear of the count to 0; also aborts a load
//   enable    : count enable (level)
//   up_down   : 1 = count up, 0 = count down
//   load      : load request, honoured only while not busy
//   data_in   : unsigned binary load value
//   bcd_out   : current count, digit 0 (units) in bits [3:0]
//   busy      : high while a load conversion is in progress
//   tc        : one-cycle pulse on a limit event (wrap or saturate hit)
//   load_err  : one-cycle pulse when data_in was clamped to MAX_VALUE
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int unsigned DIGITS       = 6,
    parameter int unsigned TICK_DIV     = 12_500_000,
    parameter int unsigned MAX_VALUE    = 999_999,
    parameter bit          SATURATE     = 1'b0,
    parameter int unsigned DATA_IN_SIZE = 20
) (
    input  logic                      clk,
    input  logic                      rst_btn,
    input  logic                      clear,
    input  logic                      enable,
    input  logic                      up_down,
    input  logic                      load,
    input  logic [DATA_IN_SIZE-1:0]   data_in,
    output logic [4*DIGITS-1:0]       bcd_out,
    output logic                      busy,
    output logic                      tc,
    output logic                      load_err
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ITER_W = $clog2(DATA_IN_SIZE + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_IN_SIZE);
    localparam logic [63:0]       MAX_64    = 64'(MAX_VALUE);

    // Elaboration-time conversion of MAX_VALUE to its BCD form.
    function automatic logic [BCD_W-1:0] const_to_bcd(input int unsigned value);
        logic [BCD_W-1:0] r;
        int unsigned      v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    localparam logic [BCD_W-1:0] MAX_BCD = const_to_bcd(MAX_VALUE);

    // Decimal increment with carry ripple across digits.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decimal decrement with borrow ripple across digits.
    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Shift-add-3 pre-shift correction: any digit >= 5 gets +3 so the
    // following left shift carries correctly into the next decade.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [BCD_W-1:0]     count_q, count_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [DATA_IN_SIZE-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     conv_q, conv_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic                 busy_q, busy_d;
    logic                 tc_q, tc_d;
    logic                 load_err_q, load_err_d;

    logic                    load_clamp;
    logic [DATA_IN_SIZE-1:0] load_val;
    logic [BCD_W-1:0]        conv_adj;
    logic                    tick;

    // Load value clamping; a clamp implies MAX_VALUE fits in DATA_IN_SIZE bits.
    assign load_clamp = (64'(data_in) > MAX_64);
    assign load_val   = load_clamp ? DATA_IN_SIZE'(MAX_VALUE) : data_in;
    assign conv_adj   = dd_adjust(conv_q);

    // Next-state, datapath and output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_d      = pre_q;
        bin_d      = bin_q;
        conv_d     = conv_q;
        iter_d     = iter_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        tick       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (clear) begin
                    count_d = '0;
                    pre_d   = '0;
                end else if (load) begin
                    state_d    = ST_CONV;
                    pre_d      = '0;
                    bin_d      = load_val;
                    conv_d     = '0;
                    iter_d     = '0;
                    load_err_d = load_clamp;
                end else if (enable) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        tick  = 1'b1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end else begin
                    pre_d = '0;
                end

                if (tick) begin
                    if (up_down) begin
                        if (count_q >= MAX_BCD) begin
                            tc_d    = 1'b1;
                            count_d = SATURATE ? count_q : '0;
                        end else begin
                            count_d = bcd_inc(count_q);
                        end
                    end else begin
                        if (count_q == '0) begin
                            tc_d    = 1'b1;
                            count_d = SATURATE ? count_q : MAX_BCD;
                        end else begin
                            count_d = bcd_dec(count_q);
                        end
                    end
                end
            end

            ST_CONV: begin
                pre_d = '0;
                if (clear) begin
                    count_d = '0;
                    state_d = ST_RUN;
                end else if (iter_q == ITER_LAST) begin
                    // All bits shifted in; commit and resume counting.
                    count_d = conv_q;
                    state_d = ST_RUN;
                end else begin
                    conv_d = {conv_adj[BCD_W-2:0], bin_q[DATA_IN_SIZE-1]};
                    bin_d  = bin_q << 1;
                    iter_d = iter_q + ITER_W'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        busy_d = (state_d == ST_CONV);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            pre_q      <= '0;
            bin_q      <= '0;
            conv_q     <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            bin_q      <= bin_d;
            conv_q     <= conv_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd_out  = count_q;
    assign busy     = busy_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//   Scoreboard bench for bcd_updown_counter. Three instances:
//     a : 6 digits, TICK_DIV=4, wrap      (own inputs)
//     b : 6 digits, TICK_DIV=1, saturate  (shared inputs with c)
//     c : 2 digits, MAX_VALUE=59, TICK_DIV=1, 6-bit loads
//   Stimulus pushes hand-computed expectations tagged with the cycle they
//   apply to; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, clr_a, en_a, ud_a, ld_a;
    logic [19:0] din_a;
    logic [23:0] bcd_a;
    logic        busy_a, tc_a, err_a;

    logic        rst_2, clr_2, en_2, ud_2, ld_2;
    logic [19:0] din_2;
    logic [23:0] bcd_b;
    logic        busy_b, tc_b, err_b;
    logic [7:0]  bcd_c;
    logic        busy_c, tc_c, err_c;

    bcd_updown_counter #(
        .DIGITS(6), .TICK_DIV(4), .MAX_VALUE(999_999), .SATURATE(1'b0), .DATA_IN_SIZE(20)
    ) u_dut_a (
        .clk(clk), .rst_btn(rst_a), .clear(clr_a), .enable(en_a), .up_down(ud_a),
        .load(ld_a), .data_in(din_a), .bcd_out(bcd_a), .busy(busy_a), .tc(tc_a),
        .load_err(err_a)
    );

    bcd_updown_counter #(
        .DIGITS(6), .TICK_DIV(1), .MAX_VALUE(999_999), .SATURATE(1'b1), .DATA_IN_SIZE(20)
    ) u_dut_b (
        .clk(clk), .rst_btn(rst_2), .clear(clr_2), .enable(en_2), .up_down(ud_2),
        .load(ld_2), .data_in(din_2), .bcd_out(bcd_b), .busy(busy_b), .tc(tc_b),
        .load_err(err_b)
    );

    bcd_updown_counter #(
        .DIGITS(2), .TICK_DIV(1), .MAX_VALUE(59), .SATURATE(1'b0), .DATA_IN_SIZE(6)
    ) u_dut_c (
        .clk(clk), .rst_btn(rst_2), .clear(clr_2), .enable(en_2), .up_down(ud_2),
        .load(ld_2), .data_in(din_2[5:0]), .bcd_out(bcd_c), .busy(busy_c), .tc(tc_c),
        .load_err(err_c)
    );

    typedef struct {
        int unsigned at;
        int          dut;
        string       name;
        logic [23:0] bcd;
        logic        tc;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic sb_push(input int unsigned at, input int dut, input string nm,
                           input logic [23:0] b, input logic t, input logic bz,
                           input logic e);
        exp_t x;
        x.at   = at;
        x.dut  = dut;
        x.name = nm;
        x.bcd  = b;
        x.tc   = t;
        x.busy = bz;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: compare every expectation due this cycle.
    exp_t        mon_e;
    logic [26:0] mon_act, mon_want;
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at <= cyc) begin
                mon_e = sb_q[i];
                sb_q.delete(i);
                n_vec++;
                if (mon_e.at < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check for cycle %0d missed (now %0d)",
                             mon_e.name, mon_e.at, cyc);
                end else begin
                    case (mon_e.dut)
                        0:       mon_act = {bcd_a, tc_a, busy_a, err_a};
                        1:       mon_act = {bcd_b, tc_b, busy_b, err_b};
                        default: mon_act = {16'h0, bcd_c, tc_c, busy_c, err_c};
                    endcase
                    mon_want = {mon_e.bcd, mon_e.tc, mon_e.busy, mon_e.err};
                    if (mon_act !== mon_want) begin
                        n_fail++;
                        $display("FAIL %s @cyc %0d: got bcd=%h tc=%b busy=%b err=%b, want bcd=%h tc=%b busy=%b err=%b",
                                 mon_e.name, cyc, mon_act[26:3], mon_act[2], mon_act[1], mon_act[0],
                                 mon_e.bcd, mon_e.tc, mon_e.busy, mon_e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned b;

        rst_a = 1'b0; clr_a = 1'b0; en_a = 1'b0; ud_a = 1'b0; ld_a = 1'b0; din_a = '0;
        rst_2 = 1'b0; clr_2 = 1'b0; en_2 = 1'b0; ud_2 = 1'b0; ld_2 = 1'b0; din_2 = '0;

        // Reset held for two edges
        for (int d = 0; d < 3; d++) begin
            sb_push(1, d, "reset_edge1", 24'h0, 1'b0, 1'b0, 1'b0);
            sb_push(2, d, "reset_edge2", 24'h0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        wait_until(2);

        // Counting up, TICK_DIV=4: step every 4 cycles with decimal carries
        rst_a = 1'b1; rst_2 = 1'b1; en_a = 1'b1; ud_a = 1'b1;
        b = cyc;
        sb_push(b + 3,   0, "cnt_before_first", 24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 4,   0, "cnt_first_step",   24'h000001, 1'b0, 1'b0, 1'b0);
        sb_push(b + 36,  0, "cnt_9",            24'h000009, 1'b0, 1'b0, 1'b0);
        sb_push(b + 40,  0, "cnt_carry_10",     24'h000010, 1'b0, 1'b0, 1'b0);
        sb_push(b + 396, 0, "cnt_99",           24'h000099, 1'b0, 1'b0, 1'b0);
        sb_push(b + 400, 0, "cnt_carry_100",    24'h000100, 1'b0, 1'b0, 1'b0);
        wait_until(b + 400);
        en_a = 1'b0;

        // Load 25; a second load during busy is ignored
        b = cyc;
        ld_a = 1'b1; din_a = 20'd25;
        sb_push(b + 1,  0, "load25_busy",     24'h000100, 1'b0, 1'b1, 1'b0);
        sb_push(b + 21, 0, "load25_busy_end", 24'h000100, 1'b0, 1'b1, 1'b0);
        sb_push(b + 22, 0, "load25_result",   24'h000025, 1'b0, 1'b0, 1'b0);
        sb_push(b + 26, 0, "load25_ignored2", 24'h000025, 1'b0, 1'b0, 1'b0);
        wait_until(b + 1);  ld_a = 1'b0;
        wait_until(b + 5);  ld_a = 1'b1; din_a = 20'd7;
        wait_until(b + 6);  ld_a = 1'b0;
        wait_until(b + 26);

        // Up limit wrap then down limit wrap
        b = cyc;
        ld_a = 1'b1; din_a = 20'd999998;
        sb_push(b + 22, 0, "up_load_999998",  24'h999998, 1'b0, 1'b0, 1'b0);
        sb_push(b + 26, 0, "up_999999",       24'h999999, 1'b0, 1'b0, 1'b0);
        sb_push(b + 30, 0, "up_wrap_tc",      24'h000000, 1'b1, 1'b0, 1'b0);
        sb_push(b + 31, 0, "up_tc_one_cycle", 24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 34, 0, "down_wrap_tc",    24'h999999, 1'b1, 1'b0, 1'b0);
        sb_push(b + 35, 0, "down_tc_drop",    24'h999999, 1'b0, 1'b0, 1'b0);
        sb_push(b + 38, 0, "down_borrow",     24'h999998, 1'b0, 1'b0, 1'b0);
        wait_until(b + 1);  ld_a = 1'b0;
        wait_until(b + 22); en_a = 1'b1; ud_a = 1'b1;
        wait_until(b + 31); ud_a = 1'b0;
        wait_until(b + 38); en_a = 1'b0;

        // Clamp of an out-of-range load
        b = cyc;
        ld_a = 1'b1; din_a = 20'hFFFFF;
        sb_push(b + 1,  0, "clamp_err_pulse", 24'h999998, 1'b0, 1'b1, 1'b1);
        sb_push(b + 2,  0, "clamp_err_drop",  24'h999998, 1'b0, 1'b1, 1'b0);
        sb_push(b + 22, 0, "clamp_result",    24'h999999, 1'b0, 1'b0, 1'b0);
        wait_until(b + 1);  ld_a = 1'b0;
        wait_until(b + 22);

        // Clear aborts a conversion part way through
        b = cyc;
        ld_a = 1'b1; din_a = 20'd25;
        sb_push(b + 11, 0, "conv_mid_busy",  24'h999999, 1'b0, 1'b1, 1'b0);
        sb_push(b + 12, 0, "conv_clear",     24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 23, 0, "conv_no_commit", 24'h000000, 1'b0, 1'b0, 1'b0);
        wait_until(b + 1);  ld_a = 1'b0;
        wait_until(b + 11); clr_a = 1'b1;
        wait_until(b + 12); clr_a = 1'b0;
        wait_until(b + 23);

        // Load held high is re-accepted on the first RUN cycle
        b = cyc;
        ld_a = 1'b1; din_a = 20'd3;
        sb_push(b + 22, 0, "held_load_done",   24'h000003, 1'b0, 1'b0, 1'b0);
        sb_push(b + 23, 0, "held_load_again",  24'h000003, 1'b0, 1'b1, 1'b0);
        sb_push(b + 44, 0, "held_load_done2",  24'h000003, 1'b0, 1'b0, 1'b0);
        wait_until(b + 23); ld_a = 1'b0;
        wait_until(b + 44);

        // Reset and clear while counting
        b = cyc;
        en_a = 1'b1; ud_a = 1'b1;
        sb_push(b + 8,  0, "run_5",          24'h000005, 1'b0, 1'b0, 1'b0);
        sb_push(b + 10, 0, "run_reset",      24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 14, 0, "run_after_rst",  24'h000001, 1'b0, 1'b0, 1'b0);
        sb_push(b + 16, 0, "run_clear",      24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 19, 0, "run_clr_presc",  24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 20, 0, "run_after_clr",  24'h000001, 1'b0, 1'b0, 1'b0);
        wait_until(b + 9);  rst_a = 1'b0;
        wait_until(b + 10); rst_a = 1'b1;
        wait_until(b + 15); clr_a = 1'b1;
        wait_until(b + 16); clr_a = 1'b0;
        wait_until(b + 20); en_a = 1'b0;

        // Saturating instance and 2-digit modulo-60 instance
        b = cyc;
        ld_2 = 1'b1; din_2 = 20'd999998;
        sb_push(b + 1,  1, "sat_load_busy",   24'h000000, 1'b0, 1'b1, 1'b0);
        sb_push(b + 1,  2, "m60_clamp_err",   24'h000000, 1'b0, 1'b1, 1'b1);
        sb_push(b + 8,  2, "m60_clamp_res",   24'h000059, 1'b0, 1'b0, 1'b0);
        sb_push(b + 22, 1, "sat_load_res",    24'h999998, 1'b0, 1'b0, 1'b0);
        sb_push(b + 23, 1, "sat_reach_max",   24'h999999, 1'b0, 1'b0, 1'b0);
        sb_push(b + 23, 2, "m60_up_wrap",     24'h000000, 1'b1, 1'b0, 1'b0);
        sb_push(b + 24, 1, "sat_hold_tc1",    24'h999999, 1'b1, 1'b0, 1'b0);
        sb_push(b + 24, 2, "m60_step_1",      24'h000001, 1'b0, 1'b0, 1'b0);
        sb_push(b + 25, 1, "sat_hold_tc2",    24'h999999, 1'b1, 1'b0, 1'b0);
        sb_push(b + 26, 1, "sat_clear",       24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 26, 2, "m60_clear",       24'h000000, 1'b0, 1'b0, 1'b0);
        sb_push(b + 27, 1, "sat_hold_zero",   24'h000000, 1'b1, 1'b0, 1'b0);
        sb_push(b + 27, 2, "m60_down_wrap",   24'h000059, 1'b1, 1'b0, 1'b0);
        sb_push(b + 28, 1, "sat_hold_zero2",  24'h000000, 1'b1, 1'b0, 1'b0);
        sb_push(b + 28, 2, "m60_down_58",     24'h000058, 1'b0, 1'b0, 1'b0);
        sb_push(b + 30, 2, "m60_stopped",     24'h000058, 1'b0, 1'b0, 1'b0);
        wait_until(b + 1);  ld_2 = 1'b0;
        wait_until(b + 22); en_2 = 1'b1; ud_2 = 1'b1;
        wait_until(b + 25); clr_2 = 1'b1; ud_2 = 1'b0;
        wait_until(b + 26); clr_2 = 1'b0;
        wait_until(b + 28); en_2 = 1'b0;
        wait_until(b + 31);

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        foreach (sb_q[i]) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", sb_q[i].name, sb_q[i].at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
